// File: rtl/data_bus_pkg.sv
// Types and helpers for the two-master data bus in front of the data memory.
//   bus_req_t     : one master's request fields, bundled
//   master_id_t   : which master (M0 = CPU, M1 = debug/DMA)
//   MEM_WORD_BITS : width of the memory word address
//   is_data_addr  : byte address falls inside the data memory window
package data_bus_pkg;

   localparam int unsigned MEM_WORD_BITS = rv_config::DATA_BITS - 2;

   typedef enum logic {
      Master0 = 1'b0,
      Master1 = 1'b1
   } master_id_t;

   typedef struct packed {
      logic [31:0] address;
      logic [31:0] write_data;
      logic [3:0]  byte_enable;
      logic        write_enable;
      logic        lock;
   } bus_req_t;

   function automatic logic is_data_addr(input logic [31:0] addr);
      return (addr >= rv_config::DATA_BEGIN) && (addr <= rv_config::DATA_END);
   endfunction

endpackage

// File: rtl/rv_config.sv
// Platform memory map shared by the data-side blocks.
//   DATA_BITS  : byte-address width of the data memory
//   DATA_BEGIN : first byte address mapped to data memory (inclusive)
//   DATA_END   : last byte address mapped to data memory (inclusive)
package rv_config;

   localparam int unsigned DATA_BITS  = 13;
   localparam logic [31:0] DATA_BEGIN = 32'h0000_1000;
   localparam logic [31:0] DATA_END   = 32'h0000_1FFF;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter with round-robin or fixed priority and bounded lock holding.
//   clock, reset_n : clock, asynchronous active-low reset
//   req[1:0]       : per-master request
//   lock[1:0]      : per-master request to keep the grant next cycle
//   accept         : a transfer completes on this edge
//   grant[1:0]     : one-hot winner (combinational), zero when nobody requests
module rr_arbiter2
   import data_bus_pkg::*;
#(
   parameter bit          FIXED_PRIORITY = 1'b0,
   parameter int unsigned MAX_HOLD       = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic [1:0] lock,
   input  logic       accept,
   output logic [1:0] grant
);

   localparam int unsigned HoldBits = $clog2(MAX_HOLD + 1);
   localparam logic [HoldBits-1:0] HoldMax = HoldBits'(MAX_HOLD);

   master_id_t          last_grant_q, last_grant_d;
   logic [HoldBits-1:0] hold_cnt_q, hold_cnt_d;
   // Previous cycle completed a locked transfer (by last_grant_q).
   logic                lock_q, lock_d;
   master_id_t          winner;
   logic                hold_ok;

   always_comb begin
      winner  = Master0;
      // Lock keeps the grant until the hold budget runs out; beyond the budget a lone
      // requester still wins through the normal single-requester path.
      hold_ok = lock_q && req[last_grant_q] && (hold_cnt_q < HoldMax);
      if (hold_ok) begin
         winner = last_grant_q;
      end else if (req[0] && req[1]) begin
         if (FIXED_PRIORITY) begin
            winner = Master0;
         end else begin
            winner = (last_grant_q == Master0) ? Master1 : Master0;
         end
      end else if (req[1]) begin
         winner = Master1;
      end
   end

   assign grant[0] = req[0] && (winner == Master0);
   assign grant[1] = req[1] && (winner == Master1);

   always_comb begin
      last_grant_d = last_grant_q;
      hold_cnt_d   = '0;
      lock_d       = 1'b0;
      if (accept) begin
         last_grant_d = winner;
         lock_d       = lock[winner];
         // Count only consecutive locked transfers by the same master.
         if (lock[winner] && lock_q && (winner == last_grant_q)) begin
            hold_cnt_d = (hold_cnt_q == HoldMax) ? HoldMax : hold_cnt_q + HoldBits'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= Master1;
         hold_cnt_q   <= '0;
         lock_q       <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         hold_cnt_q   <= hold_cnt_d;
         lock_q       <= lock_d;
      end
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port synchronous data memory between M0 (CPU) and M1 (debug/DMA).
//   clock, reset_n        : clock, asynchronous active-low reset
//   mN_req/lock           : request valid, keep grant next cycle (burst)
//   mN_address/write_data : byte address, write data
//   mN_byte_enable        : byte lanes
//   mN_write_enable       : 1 = write, 0 = read
//   mN_gnt                : request accepted this cycle (combinational)
//   mN_rvalid/read_data   : read response, one cycle after the accepted read
//   mem_*                 : memory address/strobe/lanes/data, driven from the winner
//   mem_q                 : memory read data, one cycle after the address
module data_memory_arbiter
   import data_bus_pkg::*;
#(
   parameter bit          FIXED_PRIORITY = 1'b0,
   parameter int unsigned MAX_HOLD       = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     m0_req,
   input  logic                     m0_lock,
   input  logic [31:0]              m0_address,
   input  logic [31:0]              m0_write_data,
   input  logic [3:0]               m0_byte_enable,
   input  logic                     m0_write_enable,
   output logic                     m0_gnt,
   output logic                     m0_rvalid,
   output logic [31:0]              m0_read_data,
   input  logic                     m1_req,
   input  logic                     m1_lock,
   input  logic [31:0]              m1_address,
   input  logic [31:0]              m1_write_data,
   input  logic [3:0]               m1_byte_enable,
   input  logic                     m1_write_enable,
   output logic                     m1_gnt,
   output logic                     m1_rvalid,
   output logic [31:0]              m1_read_data,
   output logic [MEM_WORD_BITS-1:0] mem_address,
   output logic                     mem_wren,
   output logic [3:0]               mem_byteena,
   output logic [31:0]              mem_data,
   input  logic [31:0]              mem_q
);

   bus_req_t   bus [2];
   logic [1:0] req_gated;
   logic [1:0] grant;
   logic       accept;
   master_id_t win_id;
   logic       win_is_data;

   logic       rd_pending_q;
   master_id_t rd_owner_q;
   logic       rd_oob_q;

   assign bus[0] = '{address: m0_address, write_data: m0_write_data,
                     byte_enable: m0_byte_enable, write_enable: m0_write_enable,
                     lock: m0_lock};
   assign bus[1] = '{address: m1_address, write_data: m1_write_data,
                     byte_enable: m1_byte_enable, write_enable: m1_write_enable,
                     lock: m1_lock};

   // Gating requests with reset keeps grants and the write strobe low while in reset,
   // even though the grant path is purely combinational.
   assign req_gated = {m1_req, m0_req} & {2{reset_n}};

   rr_arbiter2 #(
      .FIXED_PRIORITY (FIXED_PRIORITY),
      .MAX_HOLD       (MAX_HOLD)
   ) u_arb (
      .clock   (clock),
      .reset_n (reset_n),
      .req     (req_gated),
      .lock    ({bus[1].lock, bus[0].lock}),
      .accept  (accept),
      .grant   (grant)
   );

   assign accept = |grant;
   assign m0_gnt = grant[0];
   assign m1_gnt = grant[1];

   // No winner selects M0; its fields are don't-care with mem_wren low.
   assign win_id      = grant[1] ? Master1 : Master0;
   assign win_is_data = is_data_addr(bus[win_id].address);

   assign mem_address = bus[win_id].address[rv_config::DATA_BITS-1:2];
   assign mem_byteena = bus[win_id].byte_enable;
   assign mem_data    = bus[win_id].write_data;
   // Out-of-window writes are still accepted, just never reach the memory.
   assign mem_wren    = accept && bus[win_id].write_enable && win_is_data;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_pending_q <= 1'b0;
         rd_owner_q   <= Master0;
         rd_oob_q     <= 1'b0;
      end else begin
         rd_pending_q <= accept && !bus[win_id].write_enable;
         if (accept && !bus[win_id].write_enable) begin
            rd_owner_q <= win_id;
            rd_oob_q   <= !win_is_data;
         end
      end
   end

   always_comb begin
      m0_rvalid    = rd_pending_q && (rd_owner_q == Master0);
      m1_rvalid    = rd_pending_q && (rd_owner_q == Master1);
      m0_read_data = '0;
      m1_read_data = '0;
      if (m0_rvalid && !rd_oob_q) m0_read_data = mem_q;
      if (m1_rvalid && !rd_oob_q) m1_read_data = mem_q;
   end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: a round-robin instance with a behavioural memory and a
// fixed-priority instance sharing the same request inputs.
module tb_data_memory_arbiter;
   import data_bus_pkg::*;

   localparam int unsigned MaxHold  = 4;
   localparam int unsigned MemWords = 1 << MEM_WORD_BITS;
   localparam logic [31:0] DBeg = rv_config::DATA_BEGIN;
   localparam logic [31:0] DEnd = rv_config::DATA_END;

   logic clock = 1'b0;
   logic reset_n;
   logic m0_req, m0_lock, m0_write_enable, m1_req, m1_lock, m1_write_enable;
   logic [31:0] m0_address, m0_write_data, m1_address, m1_write_data;
   logic [3:0]  m0_byte_enable, m1_byte_enable;
   logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_wren;
   logic [31:0] m0_read_data, m1_read_data, mem_data, mem_q;
   logic [3:0]  mem_byteena;
   logic [MEM_WORD_BITS-1:0] mem_address;
   logic fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid, fp_mem_wren;
   logic [31:0] fp_m0_read_data, fp_m1_read_data, fp_mem_data;
   logic [31:0] fp_mem_q = 32'h0;
   logic [3:0]  fp_mem_byteena;
   logic [MEM_WORD_BITS-1:0] fp_mem_address;

   logic [31:0] mem [MemWords];

   always #5 clock = ~clock;

   data_memory_arbiter #(.FIXED_PRIORITY(1'b0), .MAX_HOLD(MaxHold)) dut (
      .clock(clock), .reset_n(reset_n),
      .m0_req(m0_req), .m0_lock(m0_lock), .m0_address(m0_address),
      .m0_write_data(m0_write_data), .m0_byte_enable(m0_byte_enable),
      .m0_write_enable(m0_write_enable), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
      .m0_read_data(m0_read_data),
      .m1_req(m1_req), .m1_lock(m1_lock), .m1_address(m1_address),
      .m1_write_data(m1_write_data), .m1_byte_enable(m1_byte_enable),
      .m1_write_enable(m1_write_enable), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
      .m1_read_data(m1_read_data),
      .mem_address(mem_address), .mem_wren(mem_wren), .mem_byteena(mem_byteena),
      .mem_data(mem_data), .mem_q(mem_q)
   );

   data_memory_arbiter #(.FIXED_PRIORITY(1'b1), .MAX_HOLD(MaxHold)) dut_fp (
      .clock(clock), .reset_n(reset_n),
      .m0_req(m0_req), .m0_lock(m0_lock), .m0_address(m0_address),
      .m0_write_data(m0_write_data), .m0_byte_enable(m0_byte_enable),
      .m0_write_enable(m0_write_enable), .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid),
      .m0_read_data(fp_m0_read_data),
      .m1_req(m1_req), .m1_lock(m1_lock), .m1_address(m1_address),
      .m1_write_data(m1_write_data), .m1_byte_enable(m1_byte_enable),
      .m1_write_enable(m1_write_enable), .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid),
      .m1_read_data(fp_m1_read_data),
      .mem_address(fp_mem_address), .mem_wren(fp_mem_wren), .mem_byteena(fp_mem_byteena),
      .mem_data(fp_mem_data), .mem_q(fp_mem_q)
   );

   // Synchronous memory, cleared while reset is held.
   always @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < MemWords; i++) mem[i] <= '0;
      end else if (mem_wren) begin
         for (int i = 0; i < 4; i++)
            if (mem_byteena[i]) mem[mem_address][8*i +: 8] <= mem_data[8*i +: 8];
      end
      mem_q <= mem[mem_address];
   end

   int checks = 0;
   int errors = 0;

   // Reference model state.
   int  mdl_last, mdl_hold, fp_last, fp_hold;
   bit  mdl_lockq, fp_lockq;
   bit  exp_pend;
   int  exp_owner;
   logic [31:0] exp_data;
   logic [31:0] shadow [int];

   // Sampled DUT outputs of the latest step.
   logic [1:0]  s_gnt, s_fgnt, s_rv;
   logic        s_wren;
   logic [31:0] s_rd0, s_rd1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit in_range(input logic [31:0] a);
      return (a >= DBeg) && (a <= DEnd);
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'(a[rv_config::DATA_BITS-1:2]);
   endfunction

   function automatic logic [31:0] shadow_rd(input logic [31:0] a);
      return shadow.exists(word_of(a)) ? shadow[word_of(a)] : 32'h0;
   endfunction

   // Winner per the arbitration rules; -1 when nobody requests.
   function automatic int model_win(input bit fixed, input int last, input int hold,
                                    input bit lockq, input logic r0, input logic r1);
      logic rl;
      rl = (last == 0) ? r0 : r1;
      if (lockq && rl && hold < int'(MaxHold)) return last;
      if (r0 && r1) return fixed ? 0 : 1 - last;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
   endfunction

   task automatic model_arb(inout int last, inout int hold, inout bit lockq,
                            input int w, input logic lk);
      if (w < 0) begin
         hold  = 0;
         lockq = 1'b0;
      end else begin
         if (lk && lockq && w == last) hold = (hold < int'(MaxHold)) ? hold + 1 : hold;
         else hold = 0;
         lockq = lk;
         last  = w;
      end
   endtask

   task automatic model_reset();
      mdl_last = 1; mdl_hold = 0; mdl_lockq = 1'b0;
      fp_last  = 1; fp_hold  = 0; fp_lockq  = 1'b0;
      exp_pend = 1'b0; exp_owner = 0; exp_data = '0;
      shadow.delete();
   endtask

   task automatic set_m0(input logic req, input logic lk, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be, input logic we);
      m0_req = req; m0_lock = lk; m0_address = a;
      m0_write_data = d; m0_byte_enable = be; m0_write_enable = we;
   endtask

   task automatic set_m1(input logic req, input logic lk, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be, input logic we);
      m1_req = req; m1_lock = lk; m1_address = a;
      m1_write_data = d; m1_byte_enable = be; m1_write_enable = we;
   endtask

   // One clock: check outputs mid-cycle against the model, then advance model on the edge.
   task automatic step(input string tag);
      int w, wf, eg, efg;
      logic [31:0] a, d, v;
      logic [3:0]  be;
      logic        we, lk;
      @(negedge clock);
      w  = model_win(1'b0, mdl_last, mdl_hold, mdl_lockq, m0_req, m1_req);
      wf = model_win(1'b1, fp_last, fp_hold, fp_lockq, m0_req, m1_req);
      s_gnt = {m1_gnt, m0_gnt}; s_fgnt = {fp_m1_gnt, fp_m0_gnt};
      s_rv = {m1_rvalid, m0_rvalid}; s_wren = mem_wren;
      s_rd0 = m0_read_data; s_rd1 = m1_read_data;
      eg  = (w < 0) ? 0 : ((w == 0) ? 1 : 2);
      efg = (wf < 0) ? 0 : ((wf == 0) ? 1 : 2);
      if (w == 1) begin
         a = m1_address; d = m1_write_data; be = m1_byte_enable;
         we = m1_write_enable; lk = m1_lock;
      end else begin
         a = m0_address; d = m0_write_data; be = m0_byte_enable;
         we = m0_write_enable; lk = m0_lock;
      end
      check({tag, ".gnt"}, 32'(s_gnt), 32'(eg));
      check({tag, ".fp_gnt"}, 32'(s_fgnt), 32'(efg));
      check({tag, ".wren"}, 32'(s_wren), 32'(w >= 0 && we && in_range(a)));
      if (w >= 0) begin
         check({tag, ".maddr"}, 32'(mem_address), 32'(word_of(a)));
         check({tag, ".mbe"}, 32'(mem_byteena), 32'(be));
         if (we) check({tag, ".mdata"}, mem_data, d);
      end
      check({tag, ".rvalid"}, 32'(s_rv),
            32'({exp_pend && exp_owner == 1, exp_pend && exp_owner == 0}));
      check({tag, ".rd0"}, s_rd0, (exp_pend && exp_owner == 0) ? exp_data : 32'h0);
      check({tag, ".rd1"}, s_rd1, (exp_pend && exp_owner == 1) ? exp_data : 32'h0);
      @(posedge clock);
      #1;
      exp_pend = 1'b0;
      if (w >= 0) begin
         if (we) begin
            if (in_range(a)) begin
               v = shadow_rd(a);
               for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = d[8*i +: 8];
               shadow[word_of(a)] = v;
            end
         end else begin
            exp_pend  = 1'b1;
            exp_owner = w;
            exp_data  = in_range(a) ? shadow_rd(a) : 32'h0;
         end
      end
      model_arb(mdl_last, mdl_hold, mdl_lockq, w, lk);
      model_arb(fp_last, fp_hold, fp_lockq, wf, (wf == 1) ? m1_lock : m0_lock);
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 9))
         0:       return 32'h0000_2000 + 32'(4 * $urandom_range(0, 15));
         1:       return DBeg - 32'd4;
         2:       return DEnd;
         default: return DBeg + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp4 [7];
      exp4 = '{2, 2, 2, 2, 2, 1, 2};
      model_reset();
      reset_n = 1'b1;
      set_m0(1'b1, 1'b0, DBeg, 32'h0, 4'hF, 1'b0);
      set_m1(1'b1, 1'b0, DBeg, 32'h0, 4'hF, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      check("rst.gnt", 32'({m1_gnt, m0_gnt}), 32'h0);
      check("rst.wren", 32'(mem_wren), 32'h0);
      check("rst.rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);
      check("rst.rd", m0_read_data | m1_read_data, 32'h0);
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;

      // Write then read back at the bottom of the window.
      set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      set_m0(1'b1, 1'b0, DBeg, 32'hDEAD_BEEF, 4'hF, 1'b1);
      step("t1.wr");
      check("t1.wr.gnt", 32'(s_gnt), 32'h1);
      check("t1.wr.wren", 32'(s_wren), 32'h1);
      set_m0(1'b1, 1'b0, DBeg, 32'h0, 4'hF, 1'b0);
      step("t1.rd");
      check("t1.rd.gnt", 32'(s_gnt), 32'h1);
      check("t1.rd.norv", 32'(s_rv), 32'h0);
      set_m0(1'b0, 1'b0, DBeg, 32'h0, 4'hF, 1'b0);
      step("t1.resp");
      check("t1.resp.rv", 32'(s_rv), 32'h1);
      check("t1.resp.rd0", s_rd0, 32'hDEAD_BEEF);
      check("t1.resp.rd1", s_rd1, 32'h0);

      // M1 writes its own word; both then read back-to-back under round-robin.
      set_m1(1'b1, 1'b0, DBeg + 32'd4, 32'hCAFE_F00D, 4'hF, 1'b1);
      step("t2.wr");
      for (int k = 0; k < 6; k++) begin
         set_m0(1'b1, 1'b0, DBeg, 32'h0, 4'hF, 1'b0);
         set_m1(1'b1, 1'b0, DBeg + 32'd4, 32'h0, 4'hF, 1'b0);
         step("t2.rr");
         check("t2.rr.gnt", 32'(s_gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
         if (k > 0) begin
            if (k % 2 == 1) begin
               check("t2.rv0", 32'(s_rv), 32'h1);
               check("t2.rd0", s_rd0, 32'hDEAD_BEEF);
            end else begin
               check("t2.rv1", 32'(s_rv), 32'h2);
               check("t2.rd1", s_rd1, 32'hCAFE_F00D);
            end
         end
      end
      set_m0(1'b0, 1'b0, DBeg, 32'h0, 4'hF, 1'b0);
      set_m1(1'b0, 1'b0, DBeg, 32'h0, 4'hF, 1'b0);
      step("t2.drain");
      check("t2.drain.rv1", 32'(s_rv), 32'h2);
      check("t2.drain.rd1", s_rd1, 32'hCAFE_F00D);

      // Fixed-priority instance: M0 always wins, M1 gets in once M0 drops.
      for (int k = 0; k < 5; k++) begin
         set_m0(1'b1, 1'b0, DBeg, 32'h0, 4'hF, 1'b0);
         set_m1(1'b1, 1'b0, DBeg + 32'd4, 32'h0, 4'hF, 1'b0);
         step("t3.both");
         check("t3.fp_gnt", 32'(s_fgnt), 32'h1);
      end
      set_m0(1'b0, 1'b0, DBeg, 32'h0, 4'hF, 1'b0);
      step("t3.m1");
      check("t3.fp_gnt_m1", 32'(s_fgnt), 32'h2);

      // Lock holding: M0 transfer first so the first conflict goes to M1.
      set_m0(1'b1, 1'b0, DBeg, 32'h0, 4'hF, 1'b0);
      set_m1(1'b0, 1'b0, DBeg, 32'h0, 4'hF, 1'b0);
      step("t4.pre");
      for (int k = 0; k < 7; k++) begin
         set_m0(1'b1, 1'b0, DBeg, 32'h0, 4'hF, 1'b0);
         set_m1(1'b1, 1'b1, DBeg + 32'd4, 32'h0, 4'hF, 1'b0);
         step("t4.lock");
         check("t4.lock.gnt", 32'(s_gnt), 32'(exp4[k]));
      end

      // Window edges: last byte is data, one past is dropped and reads as zero.
      set_m1(1'b0, 1'b0, DBeg, 32'h0, 4'hF, 1'b0);
      set_m0(1'b1, 1'b0, DEnd, 32'hA5A5_5A5A, 4'hF, 1'b1);
      step("t5.end_wr");
      check("t5.end_wr.wren", 32'(s_wren), 32'h1);
      set_m0(1'b1, 1'b0, DEnd + 32'd4, 32'h1122_3344, 4'hF, 1'b1);
      step("t5.oob_wr");
      check("t5.oob_wr.gnt", 32'(s_gnt), 32'h1);
      check("t5.oob_wr.wren", 32'(s_wren), 32'h0);
      set_m0(1'b1, 1'b0, DEnd + 32'd4, 32'h0, 4'hF, 1'b0);
      step("t5.oob_rd");
      set_m0(1'b1, 1'b0, DEnd, 32'h0, 4'hF, 1'b0);
      step("t5.end_rd");
      check("t5.oob_rd.rv", 32'(s_rv), 32'h1);
      check("t5.oob_rd.rd0", s_rd0, 32'h0);
      set_m0(1'b0, 1'b0, DEnd, 32'h0, 4'hF, 1'b0);
      step("t5.idle");
      check("t5.end_rd.rd0", s_rd0, 32'hA5A5_5A5A);

      // Reset right after an accepted M1 read discards the response.
      set_m1(1'b1, 1'b0, DBeg + 32'd4, 32'h0, 4'hF, 1'b0);
      step("t6.rd");
      check("t6.rd.gnt", 32'(s_gnt), 32'h2);
      #2 reset_n = 1'b0;
      set_m0(1'b1, 1'b0, DBeg, 32'h0, 4'hF, 1'b0);
      #1;
      check("t6.rst.gnt", 32'({fp_m1_gnt, fp_m0_gnt, m1_gnt, m0_gnt}), 32'h0);
      check("t6.rst.wren", 32'(mem_wren), 32'h0);
      check("t6.rst.rv", 32'({m1_rvalid, m0_rvalid}), 32'h0);
      check("t6.rst.rd", m0_read_data | m1_read_data, 32'h0);
      model_reset();
      repeat (2) begin
         @(negedge clock);
         check("t6.hold.rv1", 32'(m1_rvalid), 32'h0);
         check("t6.hold.gnt", 32'({m1_gnt, m0_gnt}), 32'h0);
      end
      @(posedge clock);
      #1 reset_n = 1'b1;
      step("t6.rel");
      check("t6.rel.gnt", 32'(s_gnt), 32'h1);
      set_m0(1'b0, 1'b0, DBeg, 32'h0, 4'hF, 1'b0);
      set_m1(1'b0, 1'b0, DBeg, 32'h0, 4'hF, 1'b0);
      step("t6.post");
      check("t6.post.rv", 32'(s_rv), 32'h1);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         set_m0(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 3), rand_addr(),
                $urandom(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 9) < 4));
         set_m1(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 3), rand_addr(),
                $urandom(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 9) < 4));
         step("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
